wired_fetch_queue: RTL and testbench

- Parametrised successor to the frontend's fixed 2-slot packet FIFO; sits between decode/packer and the backend issue interface.
- Accepts fetch packets of IN_WIDTH slots with arbitrary holes in the mask.
- Compacts valid slots into an instruction-granular circular queue and presents up to OUT_WIDTH oldest instructions per cycle.
- Drops stale packets whose thread/epoch tag does not match the current epoch.

---
 rtl/wired_fetch_queue_if.sv | 33 +++
 rtl/wired_fetch_queue.sv | 104 ++++++++++
 tb/tb_wired_fetch_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wired_fetch_queue_if.sv
// wired_fetch_queue_if -- packet-in / group-out handshake bundle for the
// instruction fetch queue.
//   in_*  : producer side (decode/packer) pushing IN_WIDTH-slot packets
//   out_* : consumer side (backend issue) taking OUT_WIDTH-slot groups
// master: the side that drives packets in and consumes groups (the frontend
//         pipe around the queue). slave: the queue itself.
// Payload vectors are packed per slot, slot 0 in the LSBs.
interface wired_fetch_queue_if #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int PKG_WIDTH = 32,
    parameter int TID_WIDTH = 1
);
    logic                                 in_valid_i;
    logic                                 in_ready_o;
    logic [IN_WIDTH-1:0]                  in_mask_i;
    logic [TID_WIDTH-1:0]                 in_tid_i;
    logic [IN_WIDTH-1:0][PKG_WIDTH-1:0]   in_pkg_i;
    logic                                 out_valid_o;
    logic                                 out_ready_i;
    logic [OUT_WIDTH-1:0]                 out_mask_o;
    logic [OUT_WIDTH-1:0][PKG_WIDTH-1:0]  out_pkg_o;

    modport master (
        output in_valid_i, in_mask_i, in_tid_i, in_pkg_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_mask_o, out_pkg_o
    );

    modport slave (
        input  in_valid_i, in_mask_i, in_tid_i, in_pkg_i, out_ready_i,
        output in_ready_o, out_valid_o, out_mask_o, out_pkg_o
    );
endinterface

// File: rtl/wired_fetch_queue.sv
// wired_fetch_queue -- compacting instruction queue between decode/packer
// and backend issue.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : redirect, empties the queue; flush_tid_i becomes the epoch
//   fq (slave)    : packet push (mask with holes, epoch tag) and group pop
//                   (up to OUT_WIDTH oldest instructions, all-or-nothing)
//   count_o       : occupancy in instructions
// Valid slots of a packet are squeezed together at the tail; packets from a
// stale epoch are accepted and thrown away so the producer never stalls on
// them.
module wired_fetch_queue #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int PKG_WIDTH = 32,
    parameter int TID_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [TID_WIDTH-1:0]         flush_tid_i,
    wired_fetch_queue_if.slave           fq,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH+1);
    localparam int MAX_FILL = DEPTH - IN_WIDTH;

    logic [PKG_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count;
    logic [TID_WIDTH-1:0] tid_q;

    logic [CW-1:0]                n_out;
    logic [CW-1:0]                push_cnt;
    logic [IN_WIDTH-1:0][PW-1:0]  slot_off;
    logic [OUT_WIDTH-1:0]         out_mask;
    logic                         push_acc, push_wr, pop;

    // Space check uses registered count only: a same-cycle pop never frees
    // room for the packet arriving alongside it.
    assign fq.in_ready_o  = (count <= CW'(MAX_FILL));
    assign fq.out_valid_o = (count != '0);
    assign n_out          = (count < CW'(OUT_WIDTH)) ? count : CW'(OUT_WIDTH);

    assign push_acc = !rst && fq.in_valid_i && fq.in_ready_o && !flush_i;
    assign push_wr  = push_acc && (fq.in_tid_i == tid_q);
    assign pop      = fq.out_valid_o && fq.out_ready_i && !flush_i;

    // Compaction: each set slot lands at tail + (number of set slots below it).
    always_comb begin
        push_cnt = '0;
        slot_off = '0;
        for (int s = 0; s < IN_WIDTH; s++) begin
            slot_off[s] = PW'(push_cnt);
            push_cnt    = push_cnt + CW'(fq.in_mask_i[s]);
        end
    end

    for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_out
        logic [PW-1:0] idx;
        assign idx              = head + PW'(k);
        assign out_mask[k]      = (CW'(k) < n_out);
        assign fq.out_pkg_o[k]  = out_mask[k] ? mem[idx] : '0;
    end
    assign fq.out_mask_o = out_mask;
    assign count_o       = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            tid_q <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            tid_q <= flush_tid_i;
        end else begin
            // Pointers wrap by truncation; n_out == DEPTH truncates to 0.
            if (push_wr) tail <= tail + PW'(push_cnt);
            if (pop)     head <= head + PW'(n_out);
            count <= count + (push_wr ? push_cnt : '0) - (pop ? n_out : '0);
        end
    end

    // Storage has no reset; only occupied entries are ever presented.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            for (int s = 0; s < IN_WIDTH; s++) begin
                if (fq.in_mask_i[s]) mem[tail + slot_off[s]] <= fq.in_pkg_i[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (!push_wr || (32'(count) + 32'(push_cnt) <= DEPTH));
        end
    end
endmodule

// File: tb/tb_wired_fetch_queue.sv
// tb_wired_fetch_queue -- directed bench for wired_fetch_queue.
// A queue-of-instructions model tracks the expected contents; one process
// compares every DUT output against it each cycle, and literal checks pin
// the hand-computed values of the directed scenarios.
module tb_wired_fetch_queue;
    localparam int IW = 2, OW = 2, D = 8, PKW = 32, TW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [TW-1:0] ftid = '0;
    logic [3:0]    count;

    wired_fetch_queue_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .PKG_WIDTH(PKW), .TID_WIDTH(TW)) fq ();

    wired_fetch_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .PKG_WIDTH(PKW), .TID_WIDTH(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .flush_tid_i (ftid),
        .fq          (fq),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: the queue is simply the ordered list of buffered instructions.
    logic [31:0]   mq [$];
    logic [TW-1:0] mtid = '0;

    always @(posedge clk) begin : model
        int  sz, n;
        bit  rdy;
        if (rst) begin
            mq.delete();
            mtid = '0;
        end else if (flush) begin
            mq.delete();
            mtid = ftid;
        end else begin
            sz  = mq.size();
            rdy = (D - sz) >= IW;
            n   = (sz < OW) ? sz : OW;
            if (sz != 0 && fq.out_ready_i) repeat (n) void'(mq.pop_front());
            if (fq.in_valid_i && rdy && fq.in_tid_i == mtid)
                for (int s = 0; s < IW; s++)
                    if (fq.in_mask_i[s]) mq.push_back(fq.in_pkg_i[s]);
        end
    end

    always @(negedge clk) begin : compare
        int sz, n;
        if (chk_en) begin
            sz = mq.size();
            n  = (sz < OW) ? sz : OW;
            check("in_ready",  64'(fq.in_ready_o),  64'((D - sz) >= IW));
            check("out_valid", 64'(fq.out_valid_o), 64'(sz != 0));
            check("out_mask",  64'(fq.out_mask_o),  64'((1 << n) - 1));
            check("count",     64'(count),          64'(sz));
            for (int k = 0; k < OW; k++)
                check("out_pkg", 64'(fq.out_pkg_o[k]), (k < n) ? 64'(mq[k]) : 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] m, input logic [TW-1:0] t,
                        input logic [31:0] p1, input logic [31:0] p0);
        fq.in_valid_i  = 1'b1;
        fq.in_mask_i   = m;
        fq.in_tid_i    = t;
        fq.in_pkg_i[1] = p1;
        fq.in_pkg_i[0] = p0;
    endtask

    task automatic nopush();
        fq.in_valid_i = 1'b0;
        fq.in_mask_i  = '0;
        fq.in_tid_i   = '0;
        fq.in_pkg_i   = '0;
    endtask

    function automatic logic [31:0] pv(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    initial begin
        nopush();
        fq.out_ready_i = 1'b0;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("lit_rst_count", 64'(count), 64'd0);
        check("lit_rst_ready", 64'(fq.in_ready_o), 64'd1);
        check("lit_rst_valid", 64'(fq.out_valid_o), 64'd0);
        check("lit_rst_mask",  64'(fq.out_mask_o), 64'd0);

        // basic push then pop of a full packet
        push(2'b11, 1'b0, 32'hBBBB_0001, 32'hAAAA_0001);
        step();
        nopush();
        check("lit_t1_count", 64'(count), 64'd2);
        check("lit_t1_mask",  64'(fq.out_mask_o), 64'd3);
        check("lit_t1_pkg",   64'({fq.out_pkg_o[1], fq.out_pkg_o[0]}), {32'hBBBB_0001, 32'hAAAA_0001});
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;
        check("lit_t1_pop", 64'(count), 64'd0);

        // compaction across holes
        push(2'b10, 1'b0, 32'hCCCC_0002, 32'hDEAD_DEAD);
        step();
        push(2'b01, 1'b0, 32'hBEEF_BEEF, 32'hDDDD_0002);
        step();
        nopush();
        check("lit_t2_count", 64'(count), 64'd2);
        check("lit_t2_pkg",   64'({fq.out_pkg_o[1], fq.out_pkg_o[0]}), {32'hDDDD_0002, 32'hCCCC_0002});
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;

        // fill to full, wrap, partial fill at 7
        flush = 1'b1; ftid = 1'b0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("lit_t3_ready_fill", 64'(fq.in_ready_o), 64'd1);
            push(2'b11, 1'b0, pv(2*i+1), pv(2*i));
            step();
        end
        nopush();
        check("lit_t3_full_count", 64'(count), 64'd8);
        check("lit_t3_full_ready", 64'(fq.in_ready_o), 64'd0);
        push(2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        nopush();
        check("lit_t3_blocked", 64'(count), 64'd8);
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;
        push(2'b11, 1'b0, pv(9), pv(8));
        step();
        nopush();
        check("lit_t3_wrap_count", 64'(count), 64'd8);
        check("lit_t3_wrap_pkg",   64'({fq.out_pkg_o[1], fq.out_pkg_o[0]}), {pv(3), pv(2)});
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;
        push(2'b01, 1'b0, 32'h0, pv(10));
        step();
        nopush();
        check("lit_t3_c7_count", 64'(count), 64'd7);
        check("lit_t3_c7_ready", 64'(fq.in_ready_o), 64'd0);
        fq.out_ready_i = 1'b1;
        repeat (4) step();
        fq.out_ready_i = 1'b0;
        check("lit_t3_drained", 64'(count), 64'd0);

        // same-cycle push and pop at count=1
        push(2'b01, 1'b0, 32'h0, 32'hEEEE_0005);
        step();
        push(2'b11, 1'b0, 32'h6666_0005, 32'hFFFF_0005);
        fq.out_ready_i = 1'b1;
        check("lit_t4_mask", 64'(fq.out_mask_o), 64'd1);
        step();
        fq.out_ready_i = 1'b0;
        nopush();
        check("lit_t4_count", 64'(count), 64'd2);
        check("lit_t4_pkg",   64'({fq.out_pkg_o[1], fq.out_pkg_o[0]}), {32'h6666_0005, 32'hFFFF_0005});
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;

        // flush with pending push, then epoch filtering
        push(2'b11, 1'b0, pv(21), pv(20)); step();
        push(2'b11, 1'b0, pv(23), pv(22)); step();
        push(2'b01, 1'b0, 32'h0, pv(24));  step();
        check("lit_t5_count5", 64'(count), 64'd5);
        push(2'b11, 1'b0, pv(26), pv(25));
        flush = 1'b1; ftid = 1'b1;
        step();
        flush = 1'b0; ftid = 1'b0;
        check("lit_t5_flush_count", 64'(count), 64'd0);
        check("lit_t5_flush_valid", 64'(fq.out_valid_o), 64'd0);
        push(2'b11, 1'b0, pv(28), pv(27));
        step();
        check("lit_t5_stale", 64'(count), 64'd0);
        push(2'b11, 1'b1, pv(30), pv(29));
        step();
        nopush();
        check("lit_t5_fresh", 64'(count), 64'd2);

        // reset beats flush mid-stream
        push(2'b11, 1'b1, pv(32), pv(31));
        step();
        check("lit_t6_count4", 64'(count), 64'd4);
        rst = 1'b1; flush = 1'b1; ftid = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; ftid = 1'b0;
        nopush();
        check("lit_t6_count", 64'(count), 64'd0);
        check("lit_t6_ready", 64'(fq.in_ready_o), 64'd1);
        push(2'b11, 1'b0, pv(41), pv(40));
        step();
        nopush();
        check("lit_t6_tid0", 64'(count), 64'd2);
        fq.out_ready_i = 1'b1;
        step();
        fq.out_ready_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
